// File: rtl/rvx_pkg.sv
`default_nettype none
// rvx_pkg: shared opcodes and fetch-packet field positions for the rvx front end.
package rvx_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int FETCH_PKT_W = 65;
  localparam int PKT_BP      = 64;
  localparam int PKT_PC_HI   = 63;
  localparam int PKT_PC_LO   = 32;
  localparam int PKT_INST_HI = 31;

endpackage

`default_nettype wire

// File: rtl/rvx_predecode.sv
`default_nettype none
// rvx_predecode: purely combinational control-flow flags and register fields from a 32-bit inst.
module rvx_predecode
  import rvx_pkg::*;
(
  input  logic [31:0] inst,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        is_branch,
  output logic        illegal,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode    = inst[6:0];
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  // Anything not in the 32-bit encoding space (compressed or garbage) is flagged.
  assign illegal   = (inst[1:0] != 2'b11);
  assign rd        = inst[11:7];
  assign rs1       = inst[19:15];
  assign rs2       = inst[24:20];

  // funct3/funct7 and immediate bits are decoded further down the pipe.
  assign unused_bits = ^{inst[31:25], inst[14:12]};

endmodule

`default_nettype wire

// File: rtl/id_fetch_rx.sv
`default_nettype none
// id_fetch_rx: first-word-fall-through receive queue between fetch and decode;
// drops bubbles, flushes on kill and pre-decodes the head entry.
module id_fetch_rx
  import rvx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PKT_W = FETCH_PKT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       kill,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PKT_W-1:0]           in_pkt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_bp_taken,
  output logic                       out_is_jal,
  output logic                       out_is_jalr,
  output logic                       out_is_branch,
  output logic                       out_illegal,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic [PKT_W-1:0] head;
  logic             push;
  logic             pop;

  // Bubbles complete the handshake but never occupy a slot.
  assign in_ready  = !reset && !kill && (cnt != FULL_CNT);
  assign push      = in_valid && in_ready && (in_pkt[PKT_INST_HI:0] != 32'd0);
  assign out_valid = (cnt != '0);
  assign pop       = out_valid && out_ready && !kill;
  assign count     = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (kill) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + (AW+1)'(1);
      else if (pop && !push) cnt <= cnt - (AW+1)'(1);
    end
  end

  // Storage carries no reset; out_valid masks whatever is left in it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_pkt;
  end

  assign head         = mem[rd_ptr];
  assign out_bp_taken = head[PKT_BP];
  assign out_pc       = head[PKT_PC_HI:PKT_PC_LO];
  assign out_inst     = head[PKT_INST_HI:0];

  rvx_predecode u_predecode (
    .inst      (head[PKT_INST_HI:0]),
    .is_jal    (out_is_jal),
    .is_jalr   (out_is_jalr),
    .is_branch (out_is_branch),
    .illegal   (out_illegal),
    .rd        (out_rd),
    .rs1       (out_rs1),
    .rs2       (out_rs2)
  );

endmodule

`default_nettype wire
